// File: rtl/cfg_reg_bank_if.sv
// cfg_reg_bank_if: simple rd/wr register bus.
// Master drives strobes/addr/data; slave answers.
interface cfg_reg_bank_if #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 32
) ();
  logic             wr_en;
  logic [ASIZE-1:0] wr_addr;
  logic [DSIZE-1:0] wr_data;
  logic             rd_en;
  logic [ASIZE-1:0] rd_addr;
  logic [DSIZE-1:0] rd_data;
  logic             rd_vld;
  logic             bus_err;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr,
    input  rd_data, rd_vld, bus_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr,
    output rd_data, rd_vld, bus_err
  );
endinterface

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: NREG config registers (RW/RO/PULSE/RW+INTR)
// plus IRQ status (W1C) and mask behind one rd/wr bus.
module cfg_reg_bank #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 32,
  parameter int NREG  = 8,
  parameter int BASE  = 0,
  parameter logic [2*NREG-1:0]     REG_MODE = '0,
  parameter logic [NREG*DSIZE-1:0] DEFAULT  = '0
) (
  input  logic                  clock,
  input  logic                  rst_n,
  cfg_reg_bank_if.slave         bus,
  output logic [NREG*DSIZE-1:0] reg_q,
  input  logic [NREG*DSIZE-1:0] ro_d,
  input  logic [NREG-1:0]       soft_rst,
  input  logic [NREG-1:0]       intr_trig,
  output logic                  irq
);

  localparam logic [1:0] M_RW    = 2'b00;
  localparam logic [1:0] M_RO    = 2'b01;
  localparam logic [1:0] M_PULSE = 2'b10;
  localparam logic [1:0] M_INTR  = 2'b11;

  localparam logic [ASIZE-1:0] A_ST =
    ASIZE'(BASE + NREG);
  localparam logic [ASIZE-1:0] A_MK =
    ASIZE'(BASE + NREG + 1);

  function automatic logic [1:0] mode(int i);
    return REG_MODE[2*i +: 2];
  endfunction

  // PULSE and RO registers hold no stored value.
  function automatic logic [DSIZE-1:0] rst_val(int i);
    if (mode(i) == M_RW || mode(i) == M_INTR)
      return DEFAULT[i*DSIZE +: DSIZE];
    return '0;
  endfunction

  logic [NREG-1:0][DSIZE-1:0] regs_q, regs_d;
  logic [NREG-1:0] status_q, status_d;
  logic [NREG-1:0] mask_q, mask_d;
  logic [NREG-1:0] trig_q;
  logic [DSIZE-1:0] rd_data_q, rd_data_d;
  logic rd_vld_q;
  logic bus_err_q, bus_err_d;
  logic irq_q, irq_d;

  logic [NREG-1:0] ro_m, pls_m, int_m;
  logic [NREG-1:0] wr_hit, rd_hit;
  logic wr_st, wr_mk, rd_st, rd_mk;
  logic wr_map, rd_map;
  logic [NREG-1:0] trig_edge, w1c;
  logic [DSIZE-1:0] rd_val;

  // Per-register mode masks and address decode.
  always_comb begin
    ro_m   = '0;
    pls_m  = '0;
    int_m  = '0;
    wr_hit = '0;
    rd_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      ro_m[i]   = mode(i) == M_RO;
      pls_m[i]  = mode(i) == M_PULSE;
      int_m[i]  = mode(i) == M_INTR;
      wr_hit[i] = bus.wr_addr == ASIZE'(BASE + i);
      rd_hit[i] = bus.rd_addr == ASIZE'(BASE + i);
    end
    wr_st  = bus.wr_addr == A_ST;
    wr_mk  = bus.wr_addr == A_MK;
    rd_st  = bus.rd_addr == A_ST;
    rd_mk  = bus.rd_addr == A_MK;
    wr_map = |wr_hit | wr_st | wr_mk;
    rd_map = |rd_hit | rd_st | rd_mk;
  end

  // Read mux: RO gives live ro_d, PULSE reads 0.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      rd_st: rd_val = DSIZE'(status_q);
      rd_mk: rd_val = DSIZE'(mask_q);
      |rd_hit: begin
        for (int i = 0; i < NREG; i++) begin
          if (rd_hit[i]) begin
            if (ro_m[i])
              rd_val = ro_d[i*DSIZE +: DSIZE];
            else if (!pls_m[i])
              rd_val = regs_q[i];
          end
        end
      end
      default: rd_val = '0;
    endcase
  end

  // Next state: writes, pulse decay, soft reset, irq.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREG; i++) begin
      if (pls_m[i])
        regs_d[i] = '0;
      if (bus.wr_en && wr_hit[i] && !ro_m[i])
        regs_d[i] = bus.wr_data;
      if (soft_rst[i])
        regs_d[i] = rst_val(i);
    end
    trig_edge = intr_trig & ~trig_q & int_m;
    w1c = '0;
    if (bus.wr_en && wr_st)
      w1c = bus.wr_data[NREG-1:0];
    status_d = (status_q & ~w1c) | trig_edge;
    mask_d = mask_q;
    if (bus.wr_en && wr_mk)
      mask_d = bus.wr_data[NREG-1:0];
    irq_d = |(status_q & mask_q);
    rd_data_d = rd_data_q;
    if (bus.rd_en)
      rd_data_d = rd_val;
    bus_err_d =
      (bus.wr_en && (!wr_map || |(wr_hit & ro_m))) ||
      (bus.rd_en && !rd_map);
  end

  // State registers, async active-low reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= rst_val(i);
      status_q  <= '0;
      mask_q    <= '0;
      trig_q    <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      bus_err_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      trig_q    <= intr_trig;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= bus.rd_en;
      bus_err_q <= bus_err_d;
      irq_q     <= irq_d;
    end
  end

  assign reg_q       = regs_q;
  assign irq         = irq_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// tb_cfg_reg_bank: directed checks of cfg_reg_bank.
// Bank A: reg3 PULSE; bank B: reg3 RW+INTR.
module tb_cfg_reg_bank;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam logic [2*NR-1:0] MODE_A = 8'b10_01_00_00;
  localparam logic [2*NR-1:0] MODE_B = 8'b11_01_00_00;
  localparam logic [NR*DW-1:0] DEF =
    {32'h0000_0077, 32'h0, 32'hA5A5_0001, 32'h0};

  logic clk = 1'b0;
  logic rst_n;
  logic [NR*DW-1:0] ro_d;
  logic [NR-1:0] soft_rst;
  logic [NR-1:0] intr_trig;
  logic [NR*DW-1:0] reg_q_a, reg_q_b;
  logic irq_a, irq_b;

  int n_run = 0;
  int n_fail = 0;

  cfg_reg_bank_if #(.ASIZE(AW), .DSIZE(DW)) bus_a ();
  cfg_reg_bank_if #(.ASIZE(AW), .DSIZE(DW)) bus_b ();

  cfg_reg_bank #(
    .ASIZE(AW), .DSIZE(DW), .NREG(NR), .BASE(0),
    .REG_MODE(MODE_A), .DEFAULT(DEF)
  ) u_a (
    .clock(clk), .rst_n(rst_n), .bus(bus_a),
    .reg_q(reg_q_a), .ro_d(ro_d),
    .soft_rst(soft_rst), .intr_trig(intr_trig),
    .irq(irq_a)
  );

  cfg_reg_bank #(
    .ASIZE(AW), .DSIZE(DW), .NREG(NR), .BASE(0),
    .REG_MODE(MODE_B), .DEFAULT(DEF)
  ) u_b (
    .clock(clk), .rst_n(rst_n), .bus(bus_b),
    .reg_q(reg_q_b), .ro_d(ro_d),
    .soft_rst('0), .intr_trig(intr_trig),
    .irq(irq_b)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 1'b0;
    bus_b.wr_en = 1'b0;
    bus_b.rd_en = 1'b0;
    soft_rst = '0;
  endtask

  task automatic wr_a(logic [7:0] a, logic [31:0] d);
    bus_a.wr_en = 1'b1;
    bus_a.wr_addr = a;
    bus_a.wr_data = d;
  endtask

  task automatic rd_a(logic [7:0] a);
    bus_a.rd_en = 1'b1;
    bus_a.rd_addr = a;
  endtask

  task automatic wr_b(logic [7:0] a, logic [31:0] d);
    bus_b.wr_en = 1'b1;
    bus_b.wr_addr = a;
    bus_b.wr_data = d;
  endtask

  task automatic rd_b(logic [7:0] a);
    bus_b.rd_en = 1'b1;
    bus_b.rd_addr = a;
  endtask

  initial begin
    rst_n = 1'b0;
    ro_d = '0;
    intr_trig = '0;
    bus_a.wr_addr = '0;
    bus_a.wr_data = '0;
    bus_a.rd_addr = '0;
    bus_b.wr_addr = '0;
    bus_b.wr_data = '0;
    bus_b.rd_addr = '0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    chk("rst_reg0", reg_q_a[31:0], 32'h0);
    chk("rst_reg1", reg_q_a[63:32], 32'hA5A5_0001);
    chk("rst_reg2_ro", reg_q_a[95:64], 32'h0);
    chk("rst_reg3_pulse", reg_q_a[127:96], 32'h0);
    chk("rst_b_reg3", reg_q_b[127:96], 32'h77);
    chk("rst_irq", {31'h0, irq_a}, 32'h0);
    chk("rst_rd_vld", {31'h0, bus_a.rd_vld}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_a.bus_err}, 32'h0);
    chk("rst_rd_data", bus_a.rd_data, 32'h0);

    // RW write then read
    wr_a(8'd0, 32'h1234);
    tick();
    idle();
    chk("rw_reg_q", reg_q_a[31:0], 32'h1234);
    chk("rw_no_err", {31'h0, bus_a.bus_err}, 32'h0);
    rd_a(8'd0);
    tick();
    idle();
    chk("rw_rd_vld", {31'h0, bus_a.rd_vld}, 32'h1);
    chk("rw_rd_data", bus_a.rd_data, 32'h1234);
    tick();
    chk("rd_vld_pulse", {31'h0, bus_a.rd_vld}, 32'h0);
    chk("rd_data_hold", bus_a.rd_data, 32'h1234);

    // RO write error, RO read of live ro_d
    wr_a(8'd2, 32'hFFFF_FFFF);
    tick();
    idle();
    chk("ro_wr_err", {31'h0, bus_a.bus_err}, 32'h1);
    chk("ro_wr_ignored", reg_q_a[95:64], 32'h0);
    tick();
    chk("ro_err_1cyc", {31'h0, bus_a.bus_err}, 32'h0);
    ro_d[95:64] = 32'hBEEF;
    rd_a(8'd2);
    tick();
    idle();
    chk("ro_rd", bus_a.rd_data, 32'hBEEF);

    // unmapped read / write, bits above NREG
    rd_a(8'd6);
    tick();
    idle();
    chk("unm_rd_data", bus_a.rd_data, 32'h0);
    chk("unm_rd_vld", {31'h0, bus_a.rd_vld}, 32'h1);
    chk("unm_rd_err", {31'h0, bus_a.bus_err}, 32'h1);
    wr_a(8'hFF, 32'h1);
    rd_a(8'hFE);
    tick();
    idle();
    chk("unm_both_err", {31'h0, bus_a.bus_err}, 32'h1);
    tick();
    chk("unm_err_1cyc", {31'h0, bus_a.bus_err}, 32'h0);
    wr_a(8'd5, 32'hFFFF_FFFF);
    tick();
    idle();
    rd_a(8'd5);
    tick();
    idle();
    chk("mask_hi_bits0", bus_a.rd_data, 32'h0000_000F);
    wr_a(8'd5, 32'h0);
    tick();
    idle();

    // same-cycle read and write: old value
    wr_a(8'd0, 32'h1);
    tick();
    wr_a(8'd0, 32'h2);
    rd_a(8'd0);
    tick();
    idle();
    chk("rdwr_old", bus_a.rd_data, 32'h1);
    chk("rdwr_new_q", reg_q_a[31:0], 32'h2);
    rd_a(8'd0);
    tick();
    idle();
    chk("rdwr_next", bus_a.rd_data, 32'h2);

    // PULSE
    wr_a(8'd3, 32'h5);
    tick();
    idle();
    chk("pls_one", reg_q_a[127:96], 32'h5);
    tick();
    chk("pls_back0", reg_q_a[127:96], 32'h0);
    wr_a(8'd3, 32'h6);
    tick();
    chk("pls_b2b_a", reg_q_a[127:96], 32'h6);
    wr_a(8'd3, 32'h7);
    tick();
    idle();
    chk("pls_b2b_b", reg_q_a[127:96], 32'h7);
    rd_a(8'd3);
    tick();
    idle();
    chk("pls_b2b_end", reg_q_a[127:96], 32'h0);
    chk("pls_rd0", bus_a.rd_data, 32'h0);

    // soft reset beats same-cycle write
    wr_a(8'd3, 32'h9);
    soft_rst = 4'b1000;
    tick();
    idle();
    chk("srst_pls", reg_q_a[127:96], 32'h0);
    wr_a(8'd1, 32'h2222);
    tick();
    chk("rw1_wr", reg_q_a[63:32], 32'h2222);
    wr_a(8'd1, 32'h3333);
    soft_rst = 4'b0010;
    tick();
    idle();
    chk("srst_rw1", reg_q_a[63:32], 32'hA5A5_0001);

    // interrupt on bank B
    wr_b(8'd5, 32'h8);
    tick();
    idle();
    intr_trig = 4'b1000;
    tick();
    chk("irq_not_yet", {31'h0, irq_b}, 32'h0);
    rd_b(8'd4);
    tick();
    idle();
    chk("irq_2clk", {31'h0, irq_b}, 32'h1);
    chk("status_8", bus_b.rd_data, 32'h8);
    chk("irq_a_no_intr", {31'h0, irq_a}, 32'h0);
    repeat (8) tick();
    wr_b(8'd4, 32'h8);
    tick();
    idle();
    chk("w1c_irq_lag", {31'h0, irq_b}, 32'h1);
    tick();
    chk("w1c_irq0", {31'h0, irq_b}, 32'h0);
    rd_b(8'd4);
    tick();
    idle();
    chk("level_once", bus_b.rd_data, 32'h0);
    rd_a(8'd4);
    tick();
    idle();
    chk("a_status0", bus_a.rd_data, 32'h0);

    // clear and new edge same cycle: set wins
    intr_trig = 4'b0000;
    tick();
    intr_trig = 4'b1000;
    tick();
    intr_trig = 4'b0000;
    tick();
    intr_trig = 4'b1000;
    wr_b(8'd4, 32'h8);
    tick();
    idle();
    rd_b(8'd4);
    tick();
    idle();
    chk("clr_edge_set", bus_b.rd_data, 32'h8);
    chk("clr_edge_irq", {31'h0, irq_b}, 32'h1);

    // mask change takes one cycle
    wr_b(8'd5, 32'h0);
    tick();
    idle();
    chk("mask_lag", {31'h0, irq_b}, 32'h1);
    tick();
    chk("mask_off", {31'h0, irq_b}, 32'h0);
    wr_b(8'd5, 32'h8);
    tick();
    idle();
    tick();
    chk("mask_on", {31'h0, irq_b}, 32'h1);

    // async reset mid-operation
    wr_a(8'd3, 32'h5);
    rd_a(8'd0);
    tick();
    idle();
    chk("pre_rst_pls", reg_q_a[127:96], 32'h5);
    chk("pre_rst_vld", {31'h0, bus_a.rd_vld}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pls", reg_q_a[127:96], 32'h0);
    chk("arst_irq", {31'h0, irq_b}, 32'h0);
    chk("arst_vld", {31'h0, bus_a.rd_vld}, 32'h0);
    chk("arst_rd_data", bus_a.rd_data, 32'h0);
    chk("arst_reg0", reg_q_a[31:0], 32'h0);
    chk("arst_reg1", reg_q_a[63:32], 32'hA5A5_0001);
    tick();
    rst_n = 1'b1;
    intr_trig = '0;
    tick();
    chk("post_rst_irq", {31'h0, irq_b}, 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
